// File: rtl/gen3_pkg.sv
// Shared constants and types for the Gen3 128b/130b lane scrambler sequencer.
package gen3_pkg;

  // Sync header codes
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  // Ordered-set identifiers (symbol 0 of an OS block)
  localparam logic [7:0] SKP_SYM_DEF   = 8'hAA;
  localparam logic [7:0] EIEOS_SYM_DEF = 8'h00;

  // Block geometry: 16 symbols carried as 8 beats of 2 symbols
  localparam int BLOCK_BEATS = 8;
  localparam int BEAT_BITS   = 16;

  // Scrambler LFSR: x^23 + x^21 + x^16 + x^8 + x^5 + x^2 + 1
  localparam int          LFSR_W   = 23;
  localparam logic [23:0] SEED_DEF = 24'h1DBFBC;

  typedef logic [2:0] beat_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_OS_SCR,
    ST_OS_SKP,
    ST_OS_EIE
  } scr_state_e;

endpackage

// File: rtl/gen3_lfsr_step.sv
// 23-bit Fibonacci scrambler LFSR producing 16 keystream bits per beat.
// Mask bit i is the i-th keystream bit of the beat (bit 0 scrambles the
// earliest bit of the earlier symbol). The keystream obeys
//   k[n+23] = k[n+21] ^ k[n+16] ^ k[n+8] ^ k[n+5] ^ k[n+2] ^ k[n]
// with k[0..22] taken from state bits [22..0].
module gen3_lfsr_step
  import gen3_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = SEED_DEF[LFSR_W-1:0]
) (
  input  logic                  i_pclk,
  input  logic                  i_reset,
  input  logic                  i_advance,
  input  logic                  i_load,
  input  logic [LFSR_W-1:0]     i_seed,
  output logic [BEAT_BITS-1:0]  o_mask
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_walk;
  logic [LFSR_W-1:0] w_next;

  // Unroll 16 shifts: emit the MSB, shift left, insert the feedback bit
  always_comb begin
    w_walk = r_state;
    o_mask = '0;
    for (int i = 0; i < BEAT_BITS; i++) begin
      o_mask[i] = w_walk[LFSR_W-1];
      w_walk    = {w_walk[LFSR_W-2:0],
                   w_walk[22] ^ w_walk[20] ^ w_walk[17] ^
                   w_walk[14] ^ w_walk[6]  ^ w_walk[1]};
    end
    w_next = w_walk;
  end

  // State register: seed load has priority over a 16-bit advance
  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RESET_SEED;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_advance) begin
      r_state <= w_next;
    end
  end

endmodule

// File: rtl/gen3_scrambler_seq.sv
// Gen3+ per-lane scrambler sequencer: block decode, per-symbol bypass,
// LFSR advance/hold/reload control, XOR stage and 1-deep output register.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | between blocks; next accepted beat must be a beat 0
//   ST_DATA   | data block, every symbol scrambled, LFSR advances
//   ST_OS_SCR | scrambled OS (TS1/TS2...), symbol 0 bypassed, LFSR advances
//   ST_OS_SKP | SKP OS or bad-sync block, bypass all, LFSR holds
//   ST_OS_EIE | EIEOS, bypass all, LFSR advances then reloads on beat 7
module gen3_scrambler_seq
  import gen3_pkg::*;
#(
  parameter logic [23:0] SEED      = SEED_DEF,
  parameter logic [7:0]  SKP_SYM   = SKP_SYM_DEF,
  parameter logic [7:0]  EIEOS_SYM = EIEOS_SYM_DEF
) (
  input  logic        i_pclk,
  input  logic        i_reset,
  input  logic        i_scr_reset_req,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_in_block_start,
  input  logic [1:0]  i_in_sync,
  input  logic [15:0] i_in_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_block_start,
  output logic [1:0]  o_out_sync,
  output logic [15:0] o_out_data,
  output logic        o_err_framing
);

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BLOCK_BEATS - 1);

  scr_state_e  r_state;
  scr_state_e  w_state_next;
  scr_state_e  w_decoded;
  scr_state_e  w_eff_state;
  beat_cnt_t   r_beat_cnt;
  beat_cnt_t   w_cnt_next;
  beat_cnt_t   w_eff_beat;

  logic        w_accept;
  logic        w_in_idle;
  logic        w_misplaced;
  logic        w_missing;
  logic        w_bad_sync;
  logic        w_err;
  logic        w_last;
  logic        w_rule_adv;
  logic        w_advance;
  logic        w_load;
  logic [15:0] w_scr_en;
  logic [15:0] w_mask;

  logic        r_scr_pend;
  logic        r_out_valid;
  logic        r_out_block_start;
  logic [1:0]  r_out_sync;
  logic [15:0] r_out_data;
  logic        r_err;

  // A stall at the output back-pressures the input in the same cycle
  assign o_in_ready = ~r_out_valid | i_out_ready;
  assign w_accept   = i_in_valid & o_in_ready;

  // Framing checks; beat_cnt is non-zero exactly when not idle
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_misplaced = i_in_block_start & ~w_in_idle;
  assign w_missing   = ~i_in_block_start & w_in_idle;
  assign w_bad_sync  = i_in_block_start &
                       (i_in_sync != SYNC_DATA) & (i_in_sync != SYNC_OS);
  assign w_err       = w_accept & (w_misplaced | w_missing | w_bad_sync);

  // Block-type decode from sync header and symbol 0; bad sync is treated as SKP
  always_comb begin
    w_decoded = ST_OS_SKP;
    case (i_in_sync)
      SYNC_DATA: w_decoded = ST_DATA;
      SYNC_OS: begin
        if (i_in_data[7:0] == SKP_SYM) begin
          w_decoded = ST_OS_SKP;
        end else if (i_in_data[7:0] == EIEOS_SYM) begin
          w_decoded = ST_OS_EIE;
        end else begin
          w_decoded = ST_OS_SCR;
        end
      end
      default: w_decoded = ST_OS_SKP;
    endcase
  end

  // A block start always restarts decoding, abandoning any partial block
  always_comb begin
    w_eff_state = r_state;
    w_eff_beat  = r_beat_cnt;
    if (i_in_block_start) begin
      w_eff_state = w_decoded;
      w_eff_beat  = '0;
    end
  end

  // Per-symbol scramble enables and LFSR advance rule for the current beat
  always_comb begin
    w_scr_en   = 16'h0000;
    w_rule_adv = 1'b0;
    case (w_eff_state)
      ST_DATA: begin
        w_scr_en   = 16'hFFFF;
        w_rule_adv = 1'b1;
      end
      ST_OS_SCR: begin
        w_scr_en   = (w_eff_beat == '0) ? 16'hFF00 : 16'hFFFF;
        w_rule_adv = 1'b1;
      end
      ST_OS_EIE: begin
        w_scr_en   = 16'h0000;
        w_rule_adv = 1'b1;
      end
      default: begin
        w_scr_en   = 16'h0000;
        w_rule_adv = 1'b0;
      end
    endcase
  end

  // Next state and beat counter; beat 7 wraps to idle
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_beat_cnt;
    if (w_accept) begin
      if ((w_eff_state == ST_IDLE) || (w_eff_beat == LAST_BEAT)) begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end else begin
        w_state_next = w_eff_state;
        w_cnt_next   = w_eff_beat + 1'b1;
      end
    end
  end

  // State and beat counter registers
  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_cnt_next;
    end
  end

  // Seed reload happens only at a block boundary: accepted beat 7, or while
  // idle with no beat arriving. EIEOS end and a pending request merge into one load.
  assign w_last    = w_accept & (w_eff_state != ST_IDLE) & (w_eff_beat == LAST_BEAT);
  assign w_load    = (w_last & ((w_eff_state == ST_OS_EIE) | r_scr_pend | i_scr_reset_req)) |
                     (w_in_idle & ~w_accept & r_scr_pend);
  assign w_advance = w_accept & w_rule_adv;

  // Sticky LTSSM scrambler-reset request, cleared when the reload happens
  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_scr_pend <= 1'b0;
    end else if (w_load) begin
      r_scr_pend <= 1'b0;
    end else if (i_scr_reset_req) begin
      r_scr_pend <= 1'b1;
    end
  end

  gen3_lfsr_step #(
    .RESET_SEED (SEED[LFSR_W-1:0])
  ) u_lfsr (
    .i_pclk    (i_pclk),
    .i_reset   (i_reset),
    .i_advance (w_advance),
    .i_load    (w_load),
    .i_seed    (SEED[LFSR_W-1:0]),
    .o_mask    (w_mask)
  );

  // Output register: capture on accept, drop valid once downstream takes it
  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid       <= 1'b0;
      r_out_block_start <= 1'b0;
      r_out_sync        <= 2'b00;
      r_out_data        <= 16'h0000;
    end else if (w_accept) begin
      r_out_valid       <= 1'b1;
      r_out_block_start <= i_in_block_start;
      r_out_sync        <= i_in_sync;
      r_out_data        <= i_in_data ^ (w_mask & w_scr_en);
    end else if (i_out_ready) begin
      r_out_valid       <= 1'b0;
    end
  end

  // Framing error pulse, one cycle per offending accepted beat
  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end

  assign o_out_valid       = r_out_valid;
  assign o_out_block_start = r_out_block_start;
  assign o_out_sync        = r_out_sync;
  assign o_out_data        = r_out_data;
  assign o_err_framing     = r_err;

endmodule

// File: tb/tb_gen3_scrambler_seq.sv
// Self-checking bench for gen3_scrambler_seq against a keystream-array model.
module tb_gen3_scrambler_seq;

  localparam logic [23:0] SEED   = 24'h1DBFBC;
  localparam int          KS_LEN = 2048;
  localparam int K_DATA = 0, K_TS = 1, K_SKP = 2, K_EIE = 3, K_BAD = 4;

  logic        i_pclk = 1'b0;
  logic        i_reset;
  logic        i_scr_reset_req;
  logic        i_in_valid;
  logic        o_in_ready;
  logic        i_in_block_start;
  logic [1:0]  i_in_sync;
  logic [15:0] i_in_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic        o_out_block_start;
  logic [1:0]  o_out_sync;
  logic [15:0] o_out_data;
  logic        o_err_framing;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_pos    = 0;
  int          err_seen = 0;
  bit          rand_ready = 1'b0;
  bit          ks [KS_LEN];
  logic [18:0] exp_q [$];
  logic [18:0] obs_q [$];
  logic [15:0] blk [8];

  gen3_scrambler_seq dut (
    .i_pclk            (i_pclk),
    .i_reset           (i_reset),
    .i_scr_reset_req   (i_scr_reset_req),
    .i_in_valid        (i_in_valid),
    .o_in_ready        (o_in_ready),
    .i_in_block_start  (i_in_block_start),
    .i_in_sync         (i_in_sync),
    .i_in_data         (i_in_data),
    .o_out_valid       (o_out_valid),
    .i_out_ready       (i_out_ready),
    .o_out_block_start (o_out_block_start),
    .o_out_sync        (o_out_sync),
    .o_out_data        (o_out_data),
    .o_err_framing     (o_err_framing)
  );

  always #5 i_pclk = ~i_pclk;

  // Downstream ready: always 1, or 50% random while rand_ready is set
  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(posedge i_pclk);
      #1;
      i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: record every transferred beat and every error cycle
  initial begin
    forever begin
      @(negedge i_pclk);
      if (i_reset === 1'b0) begin
        if (o_out_valid && i_out_ready)
          obs_q.push_back({o_out_block_start, o_out_sync, o_out_data});
        if (o_err_framing) err_seen++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] mask_at(input int p);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++)
      if (p + i < KS_LEN) m[i] = ks[p + i];
    return m;
  endfunction

  task automatic drive_beat(input logic st, input logic [1:0] sy, input logic [15:0] d);
    int waitc;
    waitc = 0;
    i_in_valid = 1'b1; i_in_block_start = st; i_in_sync = sy; i_in_data = d;
    forever begin
      @(negedge i_pclk);
      if (o_in_ready) break;
      waitc++;
      if (waitc > 100) begin
        n_checks++;
        $display("FAIL accept_timeout: in_ready stayed %b, required 1", o_in_ready);
        break;
      end
    end
    @(posedge i_pclk);
    #1;
    i_in_valid = 1'b0; i_in_block_start = 1'b0;
  endtask

  // Drive beats b0..b1-1 of a block and queue the expected outputs
  task automatic send_block(input int kind, input logic [15:0] d [8], input int b0, input int b1);
    logic [1:0]  sy;
    logic [15:0] m;
    logic        st;
    sy = (kind == K_DATA) ? 2'b10 : (kind == K_BAD) ? 2'b11 : 2'b01;
    for (int b = b0; b < b1; b++) begin
      m = '0;
      case (kind)
        K_DATA: begin m = mask_at(m_pos); m_pos += 16; end
        K_TS: begin
          m = mask_at(m_pos);
          if (b == 0) m[7:0] = 8'h00;
          m_pos += 16;
        end
        K_EIE: begin m_pos += 16; if (b == 7) m_pos = 0; end
        default: m = '0;
      endcase
      st = (b == 0);
      exp_q.push_back({st, sy, d[b] ^ m});
      drive_beat(st, sy, d[b]);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (obs_q.size() < exp_q.size() && c < 300) begin
      @(posedge i_pclk);
      c++;
    end
    repeat (3) @(posedge i_pclk);
    #1;
  endtask

  task automatic randomize_blk();
    foreach (blk[i]) blk[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_scr_reset_req = 1'b0; i_in_valid = 1'b0;
    i_in_block_start = 1'b0; i_in_sync = 2'b00; i_in_data = 16'h0000;
    repeat (3) @(posedge i_pclk);
    #1;
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_out_valid); else n_pass++;
    n_checks++; if (o_out_data !== 16'h0) $display("FAIL rst_data: got %h want 0000", o_out_data); else n_pass++;
    n_checks++; if (o_out_sync !== 2'b00) $display("FAIL rst_sync: got %b want 00", o_out_sync); else n_pass++;
    n_checks++; if (o_out_block_start !== 1'b0) $display("FAIL rst_bstart: got %b want 0", o_out_block_start); else n_pass++;
    n_checks++; if (o_err_framing !== 1'b0) $display("FAIL rst_err: got %b want 0", o_err_framing); else n_pass++;
    n_checks++; if (o_in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", o_in_ready); else n_pass++;
    i_reset = 1'b0;
    m_pos = 0;
  endtask

  task automatic test_data_block();
    foreach (blk[i]) blk[i] = 16'h0000;
    send_block(K_DATA, blk, 0, 8);
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL data_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL data_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (err_seen != 0) $display("FAIL data_err: got %0d want 0", err_seen); else n_pass++;
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_skp();
    foreach (blk[i]) blk[i] = 16'hAAAA;
    send_block(K_SKP, blk, 0, 8);
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL skp_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL skp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_ts1();
    randomize_blk();
    blk[0] = {8'($urandom), 8'h1E};
    send_block(K_TS, blk, 0, 8);
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL ts1_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL ts1_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_eieos();
    foreach (blk[i]) blk[i] = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
    send_block(K_EIE, blk, 0, 8);
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL eie_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL eie_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_stall();
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      randomize_blk();
      send_block(K_DATA, blk, 0, 8);
    end
    drain();
    rand_ready = 1'b0;
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL stall_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_bad_sync();
    randomize_blk();
    send_block(K_BAD, blk, 0, 8);
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (err_seen != 1) $display("FAIL badsync_err_cycles: got %0d want 1", err_seen); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL badsync_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL badsync_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_misplaced();
    randomize_blk();
    send_block(K_DATA, blk, 0, 4);
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (err_seen != 1) $display("FAIL misplaced_err_cycles: got %0d want 1", err_seen); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL misplaced_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL misplaced_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_missing_start();
    logic [15:0] d;
    d = 16'($urandom);
    exp_q.push_back({1'b0, 2'b10, d});
    drive_beat(1'b0, 2'b10, d);
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (err_seen != 1) $display("FAIL missing_err_cycles: got %0d want 1", err_seen); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL missing_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL missing_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_scr_req();
    randomize_blk();
    send_block(K_DATA, blk, 0, 4);
    i_scr_reset_req = 1'b1;
    @(posedge i_pclk);
    #1;
    i_scr_reset_req = 1'b0;
    send_block(K_DATA, blk, 4, 8);
    m_pos = 0;
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL scrreq_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL scrreq_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_reset_mid();
    randomize_blk();
    send_block(K_DATA, blk, 0, 3);
    i_in_valid = 1'b1; i_in_block_start = 1'b0; i_in_sync = 2'b10; i_in_data = blk[3];
    n_checks++; if (o_out_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", o_out_valid); else n_pass++;
    #2;
    i_reset = 1'b1;
    #1;
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", o_out_valid); else n_pass++;
    n_checks++; if (o_out_data !== 16'h0) $display("FAIL midrst_data: got %h want 0000", o_out_data); else n_pass++;
    i_in_valid = 1'b0;
    repeat (2) @(posedge i_pclk);
    #1;
    i_reset = 1'b0;
    exp_q.delete(); obs_q.delete(); err_seen = 0;
    m_pos = 0;
    randomize_blk();
    send_block(K_DATA, blk, 0, 8);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); obs_q.delete(); err_seen = 0;
  endtask

  initial begin
    logic [23:0] seed_v;
    seed_v = SEED;
    for (int k = 0; k < 23; k++) ks[k] = seed_v[22 - k];
    for (int n = 0; n + 23 < KS_LEN; n++)
      ks[n + 23] = ks[n + 21] ^ ks[n + 16] ^ ks[n + 8] ^ ks[n + 5] ^ ks[n + 2] ^ ks[n];

    test_reset();
    test_data_block();
    test_skp();
    test_ts1();
    test_eieos();
    test_stall();
    test_bad_sync();
    test_misplaced();
    test_missing_start();
    test_scr_req();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
